// File: rtl/pwm_multich_if.sv
// rtl/pwm_multich_if.sv - duty write handshake between a register master and pwm_multich
// Master drives the channel/duty request; the PWM block answers with wr_ready.
interface pwm_multich_if #(
  parameter int CH    = 3,
  parameter int WIDTH = 8
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_duty;

  modport master (output wr_valid, output wr_ch, output wr_duty, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_multich.sv
// rtl/pwm_multich.sv - multichannel PWM with prescaler, shadowed duty registers and servo mode
// Optional macro PWM_POLARITY_EN adds per-channel output polarity input pol.
module pwm_multich #(
  parameter int CH      = 3,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [PRESC_W-1:0] presc,
  input  logic               servo,
`ifdef PWM_POLARITY_EN
  input  logic [CH-1:0]      pol,
`endif
  pwm_multich_if.slave       wr,
  output logic [CH-1:0]      pwm_out,
  output logic               period_tick
);

  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH:0] SERVO_BASE = (WIDTH+1)'(1 << (WIDTH - 4));

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shadow_q [CH];
  logic [WIDTH-1:0]   shadow_d [CH];
  logic [WIDTH-1:0]   active_q [CH];
  logic [WIDTH-1:0]   active_d [CH];
  logic               servo_q, servo_d;
  logic               period_tick_q, period_tick_d;
  logic [CH-1:0]      raw_q, raw_d;
  logic [WIDTH:0]     thr;
  logic               tick;
  logic               commit;
  logic               wr_fire;

  // A presc lowered beneath the running count reloads without ticking.
  always_comb begin
    tick        = 1'b0;
    presc_cnt_d = presc_cnt_q;
    if (ena) begin
      if (presc_cnt_q == presc) begin
        tick        = 1'b1;
        presc_cnt_d = '0;
      end else if (presc_cnt_q > presc) begin
        presc_cnt_d = '0;
      end else begin
        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
      end
    end
  end

  assign commit      = tick && (cnt_q == CNT_MAX);
  assign cnt_d       = tick ? cnt_q + WIDTH'(1) : cnt_q;
  assign wr.wr_ready = rst_n && ena && !commit;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;

  always_comb begin
    servo_d       = commit ? servo : servo_q;
    period_tick_d = commit;
    for (int i = 0; i < CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_fire && (wr.wr_ch == CHW'(i))) begin
        shadow_d[i] = wr.wr_duty;
      end
      active_d[i] = commit ? shadow_q[i] : active_q[i];
    end
  end

  // All-ones duty in linear mode means 100%, which a strict compare cannot reach.
  always_comb begin
    thr   = '0;
    raw_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (servo_q) begin
        thr = SERVO_BASE + {5'b0, active_q[i][WIDTH-1:4]};
      end else begin
        thr = {1'b0, active_q[i]};
      end
      raw_d[i] = (!servo_q && (active_q[i] == CNT_MAX)) || ({1'b0, cnt_q} < thr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_q   <= '0;
      cnt_q         <= '0;
      servo_q       <= 1'b0;
      period_tick_q <= 1'b0;
      raw_q         <= '0;
      for (int i = 0; i < CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      presc_cnt_q   <= presc_cnt_d;
      cnt_q         <= cnt_d;
      servo_q       <= servo_d;
      period_tick_q <= period_tick_d;
      raw_q         <= raw_d;
      for (int i = 0; i < CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign period_tick = period_tick_q && ena;

`ifdef PWM_POLARITY_EN
  assign pwm_out = (raw_q & {CH{ena}}) ^ pol;
`else
  assign pwm_out = raw_q & {CH{ena}};
`endif

endmodule

// File: tb/tb_pwm_multich.sv
// tb/tb_pwm_multich.sv - directed self-checking bench for pwm_multich (CH=3, WIDTH=8)
module tb_pwm_multich;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        servo;
  logic [15:0] presc;
  logic [2:0]  pwm_out;
  logic        period_tick;

  int tests_run = 0;
  int fails     = 0;
  int hi [3];
  int ticks;

  pwm_multich_if #(.CH(3), .WIDTH(8)) wr ();

  pwm_multich #(.CH(3), .WIDTH(8), .PRESC_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .presc       (presc),
    .servo       (servo),
`ifdef PWM_POLARITY_EN
    .pol         (3'b000),
`endif
    .wr          (wr),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic measure(input int n);
    hi[0] = 0; hi[1] = 0; hi[2] = 0; ticks = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) hi[c] += int'(pwm_out[c]);
      ticks += int'(period_tick);
    end
  endtask

  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_tick !== 1'b1 && n < bound);
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [7:0] duty, output bit ok);
    int k;
    k = 0;
    wr.wr_valid = 1'b1;
    wr.wr_ch    = ch;
    wr.wr_duty  = duty;
    while (wr.wr_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = (wr.wr_ready === 1'b1);
    @(posedge clk);
    @(negedge clk);
    wr.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; presc = 16'd0; servo = 1'b0;
    wr.wr_valid = 1'b0; wr.wr_ch = 2'd0; wr.wr_duty = 8'd0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (pwm_out !== 3'b000) begin fails++; $display("FAIL reset_pwm: got %b expected 000", pwm_out); end
    tests_run++;
    if (period_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", period_tick); end
    tests_run++;
    if (wr.wr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", wr.wr_ready); end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (wr.wr_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b expected 1", wr.wr_ready); end
  endtask

  task automatic test_linear();
    int n; bit ok;
    wait_tick(400, n);
    tests_run++;
    if (period_tick !== 1'b1 || n != 256) begin fails++; $display("FAIL first_period: got %0d cycles expected 256", n); end
    do_write(2'd0, 8'd64, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL write_ch0: got no ready expected accept"); end
    measure(255);
    tests_run++;
    if (hi[0] != 0 || ticks != 1) begin fails++; $display("FAIL old_period: got hi0=%0d ticks=%0d expected 0/1", hi[0], ticks); end
    measure(256);
    tests_run++;
    if (hi[0] != 64 || hi[1] != 0 || hi[2] != 0 || ticks != 1) begin
      fails++; $display("FAIL duty64: got %0d/%0d/%0d ticks=%0d expected 64/0/0 ticks=1", hi[0], hi[1], hi[2], ticks);
    end
  endtask

  task automatic test_extremes();
    int n; bit ok1, ok2;
    do_write(2'd1, 8'd0, ok1);
    do_write(2'd2, 8'd255, ok2);
    wait_tick(300, n);
    tests_run++;
    if (!ok1 || !ok2 || period_tick !== 1'b1) begin fails++; $display("FAIL extremes_setup: got ok=%0d%0d tick=%b expected 11/1", ok1, ok2, period_tick); end
    measure(256);
    tests_run++;
    if (hi[0] != 64 || hi[1] != 0 || hi[2] != 256 || ticks != 1) begin
      fails++; $display("FAIL extremes: got %0d/%0d/%0d ticks=%0d expected 64/0/256 ticks=1", hi[0], hi[1], hi[2], ticks);
    end
  endtask

  task automatic test_bad_channel();
    int n; bit ok;
    do_write(2'd3, 8'd200, ok);
    wait_tick(300, n);
    measure(256);
    tests_run++;
    if (!ok || hi[0] != 64 || hi[1] != 0 || hi[2] != 256) begin
      fails++; $display("FAIL bad_channel: got ok=%0d %0d/%0d/%0d expected 1 64/0/256", ok, hi[0], hi[1], hi[2]);
    end
  endtask

  task automatic test_back_to_back();
    repeat (255) @(negedge clk);
    wr.wr_valid = 1'b1; wr.wr_ch = 2'd0; wr.wr_duty = 8'd128;
    #1;
    tests_run++;
    if (wr.wr_ready !== 1'b0) begin fails++; $display("FAIL commit_ready: got %b expected 0", wr.wr_ready); end
    @(negedge clk);
    tests_run++;
    if (wr.wr_ready !== 1'b1 || period_tick !== 1'b1) begin
      fails++; $display("FAIL after_commit: got ready=%b tick=%b expected 1/1", wr.wr_ready, period_tick);
    end
    @(negedge clk);
    wr.wr_valid = 1'b0;
    measure(255);
    tests_run++;
    if (hi[0] != 63 || ticks != 1) begin fails++; $display("FAIL late_write_old: got hi0=%0d ticks=%0d expected 63/1", hi[0], ticks); end
    measure(256);
    tests_run++;
    if (hi[0] != 128 || hi[1] != 0 || hi[2] != 256) begin
      fails++; $display("FAIL late_write_new: got %0d/%0d/%0d expected 128/0/256", hi[0], hi[1], hi[2]);
    end
  endtask

  task automatic test_servo();
    servo = 1'b1;
    measure(256);
    tests_run++;
    if (hi[0] != 128 || hi[1] != 0 || hi[2] != 256) begin
      fails++; $display("FAIL servo_pending: got %0d/%0d/%0d expected 128/0/256", hi[0], hi[1], hi[2]);
    end
    measure(256);
    tests_run++;
    if (hi[0] != 24 || hi[1] != 16 || hi[2] != 31 || ticks != 1) begin
      fails++; $display("FAIL servo_on: got %0d/%0d/%0d ticks=%0d expected 24/16/31 ticks=1", hi[0], hi[1], hi[2], ticks);
    end
    servo = 1'b0;
    measure(256);
    tests_run++;
    if (hi[0] != 24 || hi[1] != 16 || hi[2] != 31) begin
      fails++; $display("FAIL servo_hold: got %0d/%0d/%0d expected 24/16/31", hi[0], hi[1], hi[2]);
    end
    measure(256);
    tests_run++;
    if (hi[0] != 128 || hi[1] != 0 || hi[2] != 256) begin
      fails++; $display("FAIL servo_off: got %0d/%0d/%0d expected 128/0/256", hi[0], hi[1], hi[2]);
    end
  endtask

  task automatic test_ena_freeze();
    int n; int bad;
    repeat (10) @(negedge clk);
    ena = 1'b0;
    #1;
    tests_run++;
    if (pwm_out !== 3'b000 || wr.wr_ready !== 1'b0) begin
      fails++; $display("FAIL disable_now: got pwm=%b ready=%b expected 000/0", pwm_out, wr.wr_ready);
    end
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (pwm_out !== 3'b000 || period_tick !== 1'b0 || wr.wr_ready !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin fails++; $display("FAIL disabled_outputs: got %0d bad cycles expected 0", bad); end
    ena = 1'b1;
    #1;
    tests_run++;
    if (pwm_out !== 3'b101) begin fails++; $display("FAIL resume_pwm: got %b expected 101", pwm_out); end
    wait_tick(400, n);
    tests_run++;
    if (period_tick !== 1'b1 || n != 246) begin fails++; $display("FAIL resume_count: got %0d cycles expected 246", n); end
    measure(256);
    tests_run++;
    if (hi[0] != 128 || hi[1] != 0 || hi[2] != 256) begin
      fails++; $display("FAIL after_resume: got %0d/%0d/%0d expected 128/0/256", hi[0], hi[1], hi[2]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    presc = 16'd3;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (pwm_out !== 3'b000 || period_tick !== 1'b0 || wr.wr_ready !== 1'b0) begin
      fails++; $display("FAIL mid_reset: got pwm=%b tick=%b ready=%b expected 000/0/0", pwm_out, period_tick, wr.wr_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(1100, n);
    tests_run++;
    if (period_tick !== 1'b1 || n != 1024) begin fails++; $display("FAIL presc3_period: got %0d cycles expected 1024", n); end
    measure(1024);
    tests_run++;
    if (hi[0] != 0 || hi[1] != 0 || hi[2] != 0 || ticks != 1) begin
      fails++; $display("FAIL cleared_duty: got %0d/%0d/%0d ticks=%0d expected 0/0/0 ticks=1", hi[0], hi[1], hi[2], ticks);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_linear();
    test_extremes();
    test_bad_channel();
    test_back_to_back();
    test_servo();
    test_ena_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/pwm_multich.md
PWM_MULTICH -- requirements
Module: pwm_multich

Interface
REQ-001 SHALL have parameter CH, default 3, number of PWM channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 8, duty/period counter width in bits (4..12).
REQ-003 SHALL have parameter PRESC_W, default 16, prescaler divider width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  run enable.
REQ-007 SHALL have port presc  input  PRESC_W  prescaler terminal value; tick every presc+1 cycles.
REQ-008 SHALL have port servo  input  1  0 = linear duty mode, 1 = servo pulse mode.
REQ-009 SHALL have port wr_valid  input  1  duty write request.
REQ-010 SHALL have port wr_ready  output  1  duty write accept.
REQ-011 SHALL have port wr_ch  input  clog2(CH) (min 1)  target channel index.
REQ-012 SHALL have port wr_duty  input  WIDTH  new duty value.
REQ-013 SHALL have port pwm_out  output  CH  PWM outputs, bit i = channel i.
REQ-014 SHALL have port period_tick  output  1  one-cycle pulse at each period wrap.

Function
REQ-015 SHALL run prescaler counter 0..presc while ena=1, asserting internal tick when count equals presc, then reloading 0; presc=0 gives tick every cycle.
REQ-016 SHALL advance WIDTH-bit period counter by 1 per tick, wrapping 2^WIDTH-1 -> 0.
REQ-017 SHALL, while ena=0, freeze both counters, hold shadow/active duty, force pwm_out=0, period_tick=0, wr_ready=0.
REQ-018 SHALL accept a write when wr_valid=1 and wr_ready=1 in the same cycle, storing wr_duty into shadow[wr_ch]; wr_ch >= CH SHALL be accepted and discarded.
REQ-019 SHALL drive wr_ready=1 when ena=1, except in the commit cycle (tick with period counter = 2^WIDTH-1), when wr_ready=0.
REQ-020 SHALL copy all shadow registers into active registers in the commit cycle; new duty visible from first count of next period (no mid-period glitch).
REQ-021 SHALL pulse period_tick for exactly one cycle, the cycle after commit, aligned with period counter = 0.
REQ-022 SHALL compute threshold[i] = active[i] in linear mode; in servo mode threshold[i] = (2^WIDTH>>4) + (active[i]>>4), i.e. 6.25%..12.5% of period.
REQ-023 SHALL register pwm_out[i] = (count < threshold[i]), one-cycle latency from counter.
REQ-024 SHALL, in linear mode, output constant 0 for duty 0 and constant 1 for duty 2^WIDTH-1 (all-ones treated as 100%, overriding REQ-023).
REQ-025 SHALL sample servo only in the commit cycle; mode change takes effect at period boundary.
REQ-026 SHALL sample presc continuously; a presc decrease below current prescaler count SHALL force reload to 0 on next cycle.

Reset
REQ-027 SHALL, on rst_n=0, immediately clear prescaler, period counter, all shadow and active duty, latched servo mode, pwm_out=0, period_tick=0, wr_ready=0.
REQ-028 SHALL abort any in-progress period on reset mid-operation; first tick after release occurs presc+1 cycles after first enabled clock.

Configuration
REQ-029 SHALL, with macro PWM_POLARITY_EN defined, add input pol (CH bits) and drive pwm_out[i] = raw[i] XOR pol[i]; pol applied after REQ-017 forcing, so disabled outputs read pol[i].
REQ-030 SHALL, without PWM_POLARITY_EN, have no pol port and drive pwm_out = raw.

Verification
REQ-031 SHALL cover: CH=3, WIDTH=8, presc=0, write ch0 duty=64 -> from next period pwm_out[0] high 64 of 256 cycles.
REQ-032 SHALL cover: write duty=0 and duty=255 to ch1/ch2 -> ch1 constant 0, ch2 constant 1 across full periods.
REQ-033 SHALL cover: wr_valid held through commit cycle -> wr_ready=0 that cycle only, write lands one cycle later, applies one period later.
REQ-034 SHALL cover: servo=1, duty=0 and 255 -> high 16 and 31 counts per 256-count period.
REQ-035 SHALL cover: presc=3, rst_n pulsed low mid-period -> outputs 0 immediately, first tick 4 cycles after release, all duties 0.
REQ-036 SHALL cover: ena=0 for 50 cycles mid-period -> outputs 0, counters resume from frozen value on ena=1.
